// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller_if
// Purpose  : CPU / tag-data SRAM / memory bus bundle for the D-cache controller.
// Revision : 1.0  initial release
// ============================================================================
interface dcache_controller_if #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 23
);
    // CPU side
    logic [ADDR_W-1:0]  cpu_addr_i;
    logic [WORD_W-1:0]  cpu_data_i;
    logic               cpu_MemRead_i;
    logic               cpu_MemWrite_i;
    logic [WORD_W-1:0]  cpu_data_o;
    logic               cpu_stall_o;

    // Tag/data SRAM side; tag word is {valid, dirty, tag}
    logic [INDEX_W-1:0] sram_addr_o;
    logic [TAG_W+1:0]   sram_tag_o;
    logic [LINE_W-1:0]  sram_data_o;
    logic               sram_enable_o;
    logic               sram_write_o;
    logic [TAG_W+1:0]   sram_tag_i;
    logic [LINE_W-1:0]  sram_data_i;
    logic               sram_hit_i;

    // Data memory side
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [LINE_W-1:0]  mem_data_o;
    logic               mem_enable_o;
    logic               mem_write_o;
    logic [LINE_W-1:0]  mem_data_i;
    logic               mem_ack_i;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output sram_tag_i, sram_data_i, sram_hit_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Purpose  : Write-back / write-allocate L1 D-cache controller and miss FSM.
// Revision : 1.0  initial release
// ============================================================================
module dcache_controller #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 23
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    dcache_controller_if.master bus
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / WORD_W);
    localparam int BASE_W = $clog2(LINE_W);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_READMISS   = 3'd3,
        S_READMISSOK = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TAG_W-1:0]    r_victim_tag;
    logic [LINE_W-1:0]   r_victim_line;

    logic                w_req;
    logic                w_store;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [WSEL_W-1:0]   w_wsel;
    logic [BASE_W-1:0]   w_base;
    logic [LINE_W-1:0]   w_merged;
    logic                w_victim_dirty;
    logic [OFF_W-WSEL_W-1:0] w_unused_byte_bits;

    // A simultaneous read+write request is serviced as a store
    assign w_req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign w_store        = bus.cpu_MemWrite_i;
    assign w_index        = bus.cpu_addr_i[OFF_W +: INDEX_W];
    assign w_tag          = bus.cpu_addr_i[OFF_W+INDEX_W +: TAG_W];
    assign w_wsel         = bus.cpu_addr_i[OFF_W-1 -: WSEL_W];
    assign w_base         = {w_wsel, {(BASE_W-WSEL_W){1'b0}}};
    assign w_victim_dirty = bus.sram_tag_i[TAG_W+1] & bus.sram_tag_i[TAG_W];
    assign w_unused_byte_bits = bus.cpu_addr_i[OFF_W-WSEL_W-1:0];

    assign bus.sram_enable_o = w_req;
    assign bus.sram_addr_o   = w_index;
    assign bus.mem_data_o    = r_victim_line;

    always_comb begin
        w_merged = bus.sram_data_i;
        w_merged[w_base +: WORD_W] = bus.cpu_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_victim_tag  <= '0;
            r_victim_line <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_MISS) begin
                r_victim_tag  <= bus.sram_tag_i[TAG_W-1:0];
                r_victim_line <= bus.sram_data_i;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.cpu_stall_o  = 1'b1;
        bus.cpu_data_o   = '0;
        bus.sram_write_o = 1'b0;
        bus.sram_tag_o   = {1'b1, 1'b1, w_tag};
        bus.sram_data_o  = w_merged;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = {w_tag, w_index, {OFF_W{1'b0}}};
        case (r_state)
            S_IDLE: begin
                bus.cpu_stall_o = 1'b0;
                if (w_req) begin
                    if (bus.sram_hit_i) begin
                        if (w_store) begin
                            bus.sram_write_o = 1'b1;
                        end else begin
                            bus.cpu_data_o = bus.sram_data_i[w_base +: WORD_W];
                        end
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        w_next          = S_MISS;
                    end
                end
            end
            S_MISS: begin
                // SRAM presents the victim way on a miss
                w_next = w_victim_dirty ? S_WRITEBACK : S_READMISS;
            end
            S_WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {r_victim_tag, w_index, {OFF_W{1'b0}}};
                if (bus.mem_ack_i) begin
                    w_next = S_READMISS;
                end
            end
            S_READMISS: begin
                bus.mem_enable_o = 1'b1;
                if (bus.mem_ack_i) begin
                    bus.sram_write_o = 1'b1;
                    bus.sram_data_o  = bus.mem_data_i;
                    bus.sram_tag_o   = {1'b1, 1'b0, w_tag};
                    w_next           = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_inputs_stable_in_stall: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.cpu_stall_o |=> $stable({bus.cpu_addr_i, bus.cpu_data_i,
                                     bus.cpu_MemRead_i, bus.cpu_MemWrite_i}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Purpose  : Directed table, reset corner case and random traffic for the D-cache.
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_controller;
    localparam int CLK_HALF   = 5;
    localparam int ACC_BUDGET = 200;
    localparam int N_VEC      = 15;
    localparam int N_RAND     = 300;

    logic clk;
    logic rst;
    dcache_controller_if bus ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Architectural view: word memory with a deterministic initial image
    logic [31:0]  refm    [int unsigned];
    logic [255:0] backing [int unsigned];

    function automatic logic [31:0] word_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (refm.exists(a[31:2])) return refm[a[31:2]];
        return word_init({a[31:2], 2'b00});
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word({a[31:5], 5'b0} + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (backing.exists(a[31:5])) return backing[a[31:5]];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_init({a[31:5], 5'b0} + 32'(i * 4));
        return l;
    endfunction

    // 2-way tag/data SRAM with LRU replacement, invalid ways filled first
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         model_init;
    int unsigned  sram_writes;
    logic [3:0]   m_idx;
    logic         m_hit;
    logic         m_way;

    always_comb begin
        m_idx = bus.sram_addr_o;
        m_hit = 1'b0;
        m_way = s_lru[m_idx];
        if (!s_tag[m_idx][0][24]) m_way = 1'b0;
        else if (!s_tag[m_idx][1][24]) m_way = 1'b1;
        for (int w = 0; w < 2; w++) begin
            if (s_tag[m_idx][w][24] && s_tag[m_idx][w][22:0] == bus.cpu_addr_i[31:9]) begin
                m_hit = 1'b1;
                m_way = w[0];
            end
        end
        bus.sram_hit_i  = m_hit;
        bus.sram_tag_i  = s_tag[m_idx][m_way];
        bus.sram_data_i = s_data[m_idx][m_way];
    end

    always @(posedge clk) begin
        if (model_init) begin
            for (int s = 0; s < 16; s++) begin
                s_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_tag[s][w]  <= '0;
                    s_data[s][w] <= '0;
                end
            end
            sram_writes <= 0;
        end else if (bus.sram_enable_o) begin
            if (bus.sram_write_o) begin
                s_tag[m_idx][m_way]  <= bus.sram_tag_o;
                s_data[m_idx][m_way] <= bus.sram_data_o;
                sram_writes          <= sram_writes + 1;
            end
            if (!bus.cpu_stall_o || bus.sram_write_o) s_lru[m_idx] <= ~m_way;
        end
    end

    // Per-access observations
    int          n_wb, n_rd, ack_at, done_at;
    logic [31:0] wb_addr, rd_addr, last_rdata;
    bit          missed, acc_ok;

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay);
        int wait_cnt;
        n_wb = 0; n_rd = 0; ack_at = -1; done_at = -1;
        missed = 0; acc_ok = 0; wait_cnt = 0;
        @(negedge clk);
        bus.cpu_addr_i     = addr;
        bus.cpu_data_i     = wdata;
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        for (int cyc = 0; cyc < ACC_BUDGET; cyc++) begin
            #1;
            if (!bus.cpu_stall_o) begin
                last_rdata = bus.cpu_data_o;
                done_at    = cyc;
                acc_ok     = 1;
                break;
            end
            if (cyc == 0) missed = 1;
            if (bus.mem_enable_o) begin
                if (wait_cnt >= delay) begin
                    if (bus.mem_write_o) begin
                        n_wb++;
                        wb_addr = bus.mem_addr_o;
                        chk("wb_line", bus.mem_data_o, ref_line(bus.mem_addr_o));
                        backing[bus.mem_addr_o[31:5]] = bus.mem_data_o;
                    end else begin
                        n_rd++;
                        rd_addr = bus.mem_addr_o;
                        bus.mem_data_i = mem_line(bus.mem_addr_o);
                    end
                    bus.mem_ack_i = 1'b1;
                    ack_at   = cyc;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
        end
        chk("access_done", acc_ok, 1);
        if (acc_ok && wr) refm[addr[31:2]] = wdata;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_miss;
        int          exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [N_VEC];

    initial begin
        #(CLK_HALF * 2 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          found;
        int unsigned w_before;

        // Set index 2 holds 0x040/0x240/0x440/0x640/0x840 lines
        vecs[0]  = '{1, 0, 32'h040, 32'h0,        1, 0, 32'h0,   word_init(32'h040)};
        vecs[1]  = '{0, 1, 32'h044, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0};
        vecs[2]  = '{1, 0, 32'h044, 32'h0,        0, 0, 32'h0,   32'hDEADBEEF};
        vecs[3]  = '{1, 1, 32'h048, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0};
        vecs[4]  = '{1, 0, 32'h048, 32'h0,        0, 0, 32'h0,   32'hCAFEF00D};
        vecs[5]  = '{1, 0, 32'h240, 32'h0,        1, 0, 32'h0,   word_init(32'h240)};
        vecs[6]  = '{1, 0, 32'h440, 32'h0,        1, 1, 32'h040, word_init(32'h440)};
        vecs[7]  = '{1, 0, 32'h640, 32'h0,        1, 0, 32'h0,   word_init(32'h640)};
        vecs[8]  = '{0, 1, 32'h844, 32'h12345678, 1, 0, 32'h0,   32'h0};
        vecs[9]  = '{1, 0, 32'h844, 32'h0,        0, 0, 32'h0,   32'h12345678};
        vecs[10] = '{1, 0, 32'h840, 32'h0,        0, 0, 32'h0,   word_init(32'h840)};
        vecs[11] = '{1, 0, 32'h640, 32'h0,        0, 0, 32'h0,   word_init(32'h640)};
        vecs[12] = '{1, 0, 32'h040, 32'h0,        1, 1, 32'h840, word_init(32'h040)};
        vecs[13] = '{1, 0, 32'h044, 32'h0,        0, 0, 32'h0,   32'hDEADBEEF};
        vecs[14] = '{1, 0, 32'h048, 32'h0,        0, 0, 32'h0,   32'hCAFEF00D};

        rst = 1'b1;
        model_init = 1'b1;
        bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
        bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", bus.cpu_stall_o, 0);
        chk("reset_mem_enable", bus.mem_enable_o, 0);
        chk("reset_mem_write", bus.mem_write_o, 0);
        chk("reset_cpu_data", bus.cpu_data_o, 0);
        chk("reset_sram_enable", bus.sram_enable_o, 0);
        model_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 10);
            chk($sformatf("vec%0d_miss", i), missed, vecs[i].exp_miss);
            chk($sformatf("vec%0d_wb_count", i), n_wb, vecs[i].exp_wb);
            if (vecs[i].exp_wb > 0)
                chk($sformatf("vec%0d_wb_addr", i), wb_addr, vecs[i].exp_wb_addr);
            if (vecs[i].exp_miss) begin
                chk($sformatf("vec%0d_rd_count", i), n_rd, 1);
                chk($sformatf("vec%0d_rd_addr", i), rd_addr, {vecs[i].addr[31:5], 5'b0});
                chk($sformatf("vec%0d_ack_to_done", i), done_at - ack_at, 2);
            end
            if (vecs[i].rd && !vecs[i].wr)
                chk($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
        end

        // Reset while a refill is outstanding, then a stray late ack
        @(negedge clk);
        bus.cpu_addr_i = 32'hC80; bus.cpu_data_i = '0;
        bus.cpu_MemRead_i = 1'b1; bus.cpu_MemWrite_i = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.mem_enable_o && !bus.mem_write_o) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_readmiss", found, 1);
        w_before = sram_writes;
        rst = 1'b1;
        bus.cpu_MemRead_i = 1'b0;
        #1;
        chk("rst_mid_mem_enable", bus.mem_enable_o, 0);
        chk("rst_mid_mem_write", bus.mem_write_o, 0);
        chk("rst_mid_stall", bus.cpu_stall_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_data_i = '1;
        bus.mem_ack_i  = 1'b1;
        @(negedge clk);
        bus.mem_ack_i  = 1'b0;
        #1;
        chk("late_ack_stall", bus.cpu_stall_o, 0);
        chk("late_ack_mem_enable", bus.mem_enable_o, 0);
        chk("late_ack_no_sram_write", sram_writes, w_before);
        access(1, 0, 32'hC80, 32'h0, 3);
        chk("post_rst_miss", missed, 1);
        chk("post_rst_rd_count", n_rd, 1);
        chk("post_rst_rdata", last_rdata, word_init(32'hC80));

        // Random traffic over a few conflicting tags in four sets
        for (int i = 0; i < N_RAND; i++) begin
            int          tg, ix, wd, op;
            logic [31:0] a, d, exp;
            bit          rd, wr;
            tg = int'($urandom_range(0, 5));
            ix = int'($urandom_range(0, 3));
            wd = int'($urandom_range(0, 7));
            op = int'($urandom_range(0, 2));
            a  = 32'(tg * 512 + ix * 32 + wd * 4);
            d  = $urandom;
            rd = (op != 1);
            wr = (op != 0);
            exp = ref_word(a);
            access(rd, wr, a, d, int'($urandom_range(0, 4)));
            if (rd && !wr) chk("rand_load", last_rdata, exp);
            if (missed) begin
                chk("rand_rd_count", n_rd, 1);
                chk("rand_rd_addr", rd_addr, {a[31:5], 5'b0});
                chk("rand_ack_to_done", done_at - ack_at, 2);
                if (n_wb > 0) chk("rand_wb_index", wb_addr[8:0], {a[8:5], 5'b0});
            end else begin
                chk("rand_hit_no_mem", n_rd + n_wb, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
